pwm_ramp_controller: RTL and testbench
======================================

Name: pwm_ramp_controller

Overview:
- Sequences a `pwm` instance: generates its `step` strobe from a programmable prescaler and drives its `duty` input.
- Supports two modes: a glitch-free ramp to a commanded target, or a continuous triangle "breathe" between 0 and the target.
- Duty changes only at PWM period boundaries, tracked by an internal mirror of the PWM counter.
- Sits between the top-level control logic (buttons/FSM) and one or more `pwm` instances.

Parameters:
- N, 8: duty width; must match the driven `pwm` N.
- PRESCALE_W, 16: width of the prescale input.
- RATE_W, 16: width of the rate input.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (0 = in reset).
- ena  input  1  run enable; low freezes sequencing.
- prescale  input  PRESCALE_W  step period minus 1, in clk cycles.
- rate  input  RATE_W  PWM periods per duty update, minus 1.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command can be accepted.
- cmd_target  input  N  target or peak duty.
- cmd_breathe  input  1  1 = breathe mode, 0 = ramp mode.
- step  output  1  registered strobe to `pwm.step`.
- duty  output  N  registered duty to `pwm.duty`.
- busy  output  1  high in RAMP, BRTH_UP, BRTH_DN.
- done  output  1  one-cycle pulse when a ramp reaches its target.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; duty=0; step=0; done=0.
  - pre_cnt, per_cnt and rate_cnt all 0; latched target=0.
- Prescaler (ena=1):
  - pre_cnt counts 0..prescale; step=1 (registered) in the cycle after pre_cnt==prescale, then pre_cnt wraps to 0.
  - prescale=0 gives step every cycle.
- Period tracking:
  - per_cnt (N bits) increments on each step and wraps from 2^N-1 to 0.
  - period_end = step & (per_cnt == 2^N-1).
- Rate counter:
  - On period_end: if rate_cnt==rate, assert internal upd for one cycle and set rate_cnt=0; otherwise rate_cnt+1.
  - rate=0 gives an update every period.
- ena=0:
  - step=0; pre_cnt, per_cnt and rate_cnt cleared to 0.
  - FSM state and duty held.
  - Commands are still accepted wherever cmd_ready=1; the counters restart when ena returns.
- Handshake:
  - A command is accepted on cmd_valid & cmd_ready at a rising edge; cmd_target and cmd_breathe are latched.
  - Acceptance clears rate_cnt to 0.
  - cmd_valid may be held; no combinational path from cmd_valid to cmd_ready.
- FSM:
  - IDLE: cmd_ready=1. On accept → RAMP (breathe=0) or BRTH_UP (breathe=1).
  - RAMP: cmd_ready=0.
    - If duty==target → HOLD and done=1 for one cycle; this check also covers a zero-distance ramp (HOLD next cycle).
    - Otherwise, on upd, duty moves one LSB toward target.
  - HOLD: cmd_ready=1; duty constant; accept behaves as in IDLE.
  - BRTH_UP: cmd_ready=1.
    - On upd: duty+1; when new duty==target → BRTH_DN.
    - If duty>target on entry → BRTH_DN immediately.
  - BRTH_DN: cmd_ready=1.
    - On upd: duty-1; when new duty==0 → BRTH_UP.
  - Breathe with target=0 → HOLD at duty 0 with done pulse; no oscillation.
- Simultaneous accept and upd: the accept wins; the upd is discarded; duty continues from its current value under the new command.
- Arithmetic:
  - duty never wraps; it only moves toward bounds held in [0, 2^N-1].
  - Counter comparisons are unsigned.
- Latency: duty changes in the cycle after the upd cycle, i.e. aligned to PWM period start.
- Reset asserted mid-ramp or mid-breathe → outputs immediately return to their reset values.

Test Plan:
- All cases use N=4.
- Reset: rst=0 with cmd_valid=1 → duty=0, step=0, done=0, cmd_ready=1 once rst=1.
- Prescale: ena=1, prescale=2 → step high 1 of every 3 cycles; prescale=0 → step every cycle; ena=0 → step=0 and counters cleared.
- Ramp up: prescale=0, rate=0, target=3 → duty 0→1→2→3 at 16-cycle intervals, each change aligned to period_end; done one-cycle pulse on reaching 3, then HOLD with cmd_ready=1.
- Ramp down/zero distance: from HOLD duty=3, target=1 → duty 3→2→1 then done; re-issue target=1 → done the cycle after acceptance, duty unchanged.
- Breathe: target=2, rate=1 → duty 0,1,2,1,0,1,… changing every 32 cycles; busy=1; done never pulses. Command target=15 ramp mid-breathe at duty 1 → ramps from 1 to 15.
- Edge cases:
  - Breathe target=0 → HOLD with done.
  - Accept coinciding with upd → no duty change that cycle.
  - rst=0 mid-ramp → duty=0 asynchronously.

Source files
------------

// File: rtl/pwm_ramp_controller.sv
`timescale 1ns/1ps
// pwm_ramp_controller: drives the step strobe and duty input of a pwm instance.
// A prescaler generates step, a mirror of the pwm counter finds period ends, and a
// rate counter turns every (rate+1)-th period end into a duty update. The FSM either
// ramps duty to a commanded target or breathes it between 0 and the target.
module pwm_ramp_controller #(
    parameter int unsigned N          = 8,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned RATE_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [RATE_W-1:0]     rate,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [N-1:0]          cmd_target,
    input  logic                  cmd_breathe,
    output logic                  step,
    output logic [N-1:0]          duty,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        StIdle,
        StRamp,
        StHold,
        StBrthUp,
        StBrthDn
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [N-1:0]          per_cnt_q, per_cnt_d;
    logic [RATE_W-1:0]     rate_cnt_q, rate_cnt_d;
    logic [N-1:0]          target_q, target_d;
    logic [N-1:0]          duty_q, duty_d;
    logic                  step_q, step_d;
    logic                  done_q, done_d;

    logic                  pre_wrap;
    logic                  period_end;
    logic                  rate_hit;
    logic                  accept;
    logic                  upd;

    // Status outputs decoded from the registered state only, so cmd_ready never
    // depends combinationally on cmd_valid.
    always_comb begin
        cmd_ready = (state_q != StRamp);
        busy      = (state_q == StRamp) || (state_q == StBrthUp) || (state_q == StBrthDn);
    end

    assign step = step_q;
    assign duty = duty_q;
    assign done = done_q;

    assign accept = cmd_valid & cmd_ready;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------

    // >= rather than == so a prescale lowered below the running count wraps at once
    // instead of counting through the whole counter range.
    assign pre_wrap = (pre_cnt_q >= prescale);

    // Prescale counter next state and the registered step strobe.
    always_comb begin
        pre_cnt_d = '0;
        step_d    = 1'b0;
        if (ena) begin
            step_d    = pre_wrap;
            pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + 1'b1;
        end
    end

    // Prescale counter and step registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q <= '0;
            step_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            step_q    <= step_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM period mirror
    // ------------------------------------------------------------------

    // The mirror advances on the same step the pwm instance sees, so the last step of
    // its period is the one taken while the mirror sits at all-ones.
    assign period_end = step_q & (per_cnt_q == '1);

    // Period mirror next state; cleared while sequencing is frozen.
    always_comb begin
        per_cnt_d = '0;
        if (ena) begin
            per_cnt_d = step_q ? per_cnt_q + 1'b1 : per_cnt_q;
        end
    end

    // Period mirror register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Rate counter
    // ------------------------------------------------------------------

    assign rate_hit = (rate_cnt_q >= rate);

    // A new command owns the update slot: an update coinciding with acceptance is dropped.
    assign upd = ena & ~accept & period_end & rate_hit;

    // Rate counter next state; restarts on a new command or while frozen.
    always_comb begin
        rate_cnt_d = rate_cnt_q;
        if (accept || !ena) begin
            rate_cnt_d = '0;
        end else if (period_end) begin
            rate_cnt_d = rate_hit ? '0 : rate_cnt_q + 1'b1;
        end
    end

    // Rate counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_cnt_q <= '0;
        end else begin
            rate_cnt_q <= rate_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------

    // Next state, duty and done. Acceptance takes priority over everything else and
    // leaves duty where it is; the new command continues from the current value.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        done_d   = 1'b0;

        if (accept) begin
            target_d = cmd_target;
            state_d  = cmd_breathe ? StBrthUp : StRamp;
        end else if (ena) begin
            case (state_q)
                StRamp: begin
                    // Checked before the update so a zero-distance ramp finishes at once.
                    if (duty_q == target_q) begin
                        state_d = StHold;
                        done_d  = 1'b1;
                    end else if (upd) begin
                        duty_d = (duty_q < target_q) ? duty_q + 1'b1 : duty_q - 1'b1;
                    end
                end

                StBrthUp: begin
                    if ((target_q == '0) && (duty_q == '0)) begin
                        // A zero peak cannot oscillate; settle like a finished ramp.
                        state_d = StHold;
                        done_d  = 1'b1;
                    end else if (duty_q >= target_q) begin
                        // Already at or above the peak: turn round without moving.
                        state_d = StBrthDn;
                    end else if (upd) begin
                        duty_d = duty_q + 1'b1;
                        if ((duty_q + 1'b1) == target_q) begin
                            state_d = StBrthDn;
                        end
                    end
                end

                StBrthDn: begin
                    if (duty_q == '0) begin
                        state_d = StBrthUp;
                    end else if (upd) begin
                        duty_d = duty_q - 1'b1;
                        if (duty_q == {{(N-1){1'b0}}, 1'b1}) begin
                            state_d = StBrthUp;
                        end
                    end
                end

                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // FSM, latched target, duty and done registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            target_q <= '0;
            duty_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
`timescale 1ns/1ps
// Bench for pwm_ramp_controller (N=4). A reference model derives step timing and
// period ends from elapsed cycles, predicts every output change, and queues it; a
// monitor pops and compares whenever the DUT outputs change or done pulses.
module tb_pwm_ramp_controller;

    localparam int N      = 4;
    localparam int PERIOD = 16;  // 2^N steps per pwm period

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] prescale;
    logic [15:0] rate;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_target;
    logic        cmd_breathe;
    logic        step;
    logic [3:0]  duty;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pwm_ramp_controller #(
        .N          (N),
        .PRESCALE_W (16),
        .RATE_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .prescale    (prescale),
        .rate        (rate),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_breathe (cmd_breathe),
        .step        (step),
        .duty        (duty),
        .busy        (busy),
        .done        (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Output vector layout: {step, busy, cmd_ready, done, duty[3:0]}.
    typedef struct {
        int         stamp;
        logic [7:0] o;
    } ev_t;
    ev_t evq[$];
    bit  mon_en = 1'b0;

    // Reference model.
    typedef enum {MIdle, MRamp, MHold, MRise, MFall} mode_t;
    mode_t      m_mode;
    int         m_duty, m_tgt, m_rc, m_t;
    bit         m_acc;
    logic [7:0] m_last;

    // Inputs for the next cycle; applied at the falling edge together with the model step.
    bit nx_ena, nx_valid, nx_breathe;
    int nx_pre, nx_rate, nx_target;
    bit rnd_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pack(input int d, input bit dn, input bit rdy,
                                        input bit bsy, input bit stp);
        logic [3:0] d4;
        d4 = 4'(d);
        return {stp, bsy, rdy, dn, d4};
    endfunction

    // Period ends fall every PERIOD*(prescale+1) cycles after the counters restart.
    function automatic bit upd_fires();
        return ena && (m_t >= 1) && ((m_t % (PERIOD * (int'(prescale) + 1))) == 0) &&
               (m_rc == int'(rate));
    endfunction

    task automatic model_reset();
        m_mode = MIdle;
        m_duty = 0;
        m_tgt  = 0;
        m_rc   = 0;
        m_t    = 0;
        m_acc  = 1'b0;
        m_last = 8'h20;
        evq.delete();
    endtask

    task automatic model_step();
        bit pe, upd, dn, stp, bsy;
        logic [7:0] o;
        m_acc = cmd_valid && (m_mode != MRamp);
        pe    = ena && (m_t >= 1) && ((m_t % (PERIOD * (int'(prescale) + 1))) == 0);
        upd   = 1'b0;
        dn    = 1'b0;
        if (m_acc) begin
            m_tgt    = int'(cmd_target);
            m_rc     = 0;
            m_mode   = cmd_breathe ? MRise : MRamp;
            nx_valid = 1'b0;
        end else if (!ena) begin
            m_rc = 0;
        end else begin
            if (pe) begin
                if (m_rc == int'(rate)) begin
                    upd  = 1'b1;
                    m_rc = 0;
                end else begin
                    m_rc++;
                end
            end
            case (m_mode)
                MRamp: begin
                    if (m_duty == m_tgt) begin
                        m_mode = MHold;
                        dn     = 1'b1;
                    end else if (upd) begin
                        m_duty += (m_duty < m_tgt) ? 1 : -1;
                    end
                end
                MRise: begin
                    if (m_tgt == 0 && m_duty == 0) begin
                        m_mode = MHold;
                        dn     = 1'b1;
                    end else if (m_duty >= m_tgt) begin
                        m_mode = MFall;
                    end else if (upd) begin
                        m_duty++;
                        if (m_duty == m_tgt) m_mode = MFall;
                    end
                end
                MFall: begin
                    if (m_duty == 0) begin
                        m_mode = MRise;
                    end else if (upd) begin
                        m_duty--;
                        if (m_duty == 0) m_mode = MRise;
                    end
                end
                default: ;
            endcase
        end
        stp = ena && (((m_t + 1) % (int'(prescale) + 1)) == 0);
        m_t = ena ? m_t + 1 : 0;
        bsy = (m_mode == MRamp) || (m_mode == MRise) || (m_mode == MFall);
        o   = pack(m_duty, dn, m_mode != MRamp, bsy, stp);
        if (o != m_last || dn) begin
            evq.push_back('{cyc, o});
            m_last = o;
        end
    endtask

    task automatic rnd_stim();
        bit go;
        if (!cmd_valid) begin
            go = ((m_mode == MRise || m_mode == MFall) && upd_fires() &&
                  $urandom_range(0, 3) == 0) || ($urandom_range(0, 249) == 0);
            if (go) begin
                nx_valid    = 1'b1;
                nx_target   = int'($urandom_range(0, 15));
                nx_breathe  = ($urandom_range(0, 3) == 0);
                cmd_valid   = 1'b1;
                cmd_target  = 4'(nx_target);
                cmd_breathe = nx_breathe;
            end
        end
    endtask

    task automatic drive_and_model();
        ena         = nx_ena;
        prescale    = 16'(nx_pre);
        rate        = 16'(nx_rate);
        cmd_valid   = nx_valid;
        cmd_target  = 4'(nx_target);
        cmd_breathe = nx_breathe;
        if (rnd_on) rnd_stim();
        model_step();
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        drive_and_model();
    endtask

    task automatic release_tick();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        model_reset();
        mon_en = 1'b1;
        drive_and_model();
    endtask

    task automatic set_timing(input int p, input int r);
        nx_ena = 1'b0;
        repeat (2) tick();
        nx_pre  = p;
        nx_rate = r;
        tick();
        nx_ena = 1'b1;
        tick();
    endtask

    task automatic issue(input int tgt, input bit br);
        int n;
        nx_target  = tgt;
        nx_breathe = br;
        nx_valid   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 3000);
        check("cmd_accepted", int'(m_acc), 1);
        nx_valid = 1'b0;
    endtask

    // Monitor: pops an expected event whenever the DUT outputs change or done pulses.
    initial begin
        ev_t        e;
        logic [7:0] cur;
        logic [7:0] prev;
        prev = 8'h20;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                prev = 8'h20;
            end else begin
                cur = {step, busy, cmd_ready, done, duty};
                while (evq.size() > 0 && evq[0].stamp < cyc) begin
                    e = evq.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missed_event: got no change by cycle %0d expected %h at cycle %0d",
                             cyc, e.o, e.stamp);
                end
                if (cur !== prev || done === 1'b1) begin
                    total++;
                    if (evq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_change: got %h at cycle %0d expected %h held",
                                 cur, cyc, prev);
                    end else begin
                        e = evq.pop_front();
                        if (e.stamp != cyc || e.o !== cur) begin
                            bad++;
                            $display("FAIL output_event: got %h at cycle %0d expected %h at cycle %0d",
                                     cur, cyc, e.o, e.stamp);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no end by %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int n;
        int d0;

        rst         = 1'b0;
        ena         = 1'b1;
        prescale    = 16'd2;
        rate        = 16'd0;
        cmd_valid   = 1'b1;
        cmd_target  = 4'd9;
        cmd_breathe = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty), 0);
        check("rst_step", int'(step), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);

        nx_ena = 1'b1; nx_pre = 2; nx_rate = 0;
        nx_valid = 1'b0; nx_target = 0; nx_breathe = 1'b0;
        release_tick();
        check("ready_after_rst", int'(cmd_ready), 1);

        // Prescaler: 1 in 3 with prescale=2, every cycle with prescale=0, none when frozen.
        repeat (5) tick();
        cnt = 0;
        repeat (30) begin tick(); cnt += int'(step); end
        check("step_prescale2", cnt, 10);
        set_timing(0, 0);
        repeat (2) tick();
        cnt = 0;
        repeat (16) begin tick(); cnt += int'(step); end
        check("step_prescale0", cnt, 16);
        nx_ena = 1'b0;
        repeat (2) tick();
        cnt = 0;
        repeat (5) begin tick(); cnt += int'(step); end
        check("step_frozen", cnt, 0);
        set_timing(0, 0);

        // Ramp up to 3, then down to 1, then a zero-distance ramp.
        issue(3, 1'b0);
        repeat (100) tick();
        check("ramp_up_duty", int'(duty), 3);
        check("ramp_up_ready", int'(cmd_ready), 1);
        check("ramp_up_busy", int'(busy), 0);
        issue(1, 1'b0);
        repeat (100) tick();
        check("ramp_dn_duty", int'(duty), 1);
        issue(1, 1'b0);
        repeat (3) tick();
        check("zero_dist_duty", int'(duty), 1);

        // Breathe to 2 with rate=1, then ramp to 15 from duty 1.
        set_timing(0, 1);
        issue(2, 1'b1);
        repeat (300) tick();
        check("breathe_busy", int'(busy), 1);
        n = 0;
        while (m_duty != 1 && n < 300) begin tick(); n++; end
        check("breathe_reaches_1", m_duty, 1);
        issue(15, 1'b0);
        repeat (580) tick();
        check("ramp15_duty", int'(duty), 15);
        check("ramp15_busy", int'(busy), 0);

        // Breathe with zero peak settles at 0.
        issue(0, 1'b1);
        repeat (600) tick();
        check("brth0_duty", int'(duty), 0);
        check("brth0_busy", int'(busy), 0);

        // Command accepted in the same cycle as an update: duty must not move.
        issue(6, 1'b1);
        repeat (100) tick();
        n = 0;
        while (!upd_fires() && n < 200) begin tick(); n++; end
        check("upd_found", int'(upd_fires()), 1);
        d0 = m_duty;
        issue(12, 1'b0);
        tick();
        check("accept_upd_duty", int'(duty), d0);

        // Asynchronous reset mid-ramp.
        repeat (40) tick();
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_duty", int'(duty), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(cmd_ready), 1);
        check("async_rst_step", int'(step), 0);
        nx_valid = 1'b0;
        @(negedge clk);
        release_tick();

        // Randomised segments with varying prescale and rate.
        rnd_on = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            set_timing(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            repeat (1500) tick();
        end
        rnd_on = 1'b0;
        repeat (20) tick();
        @(posedge clk);
        #2;
        check("events_drained", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
